// File: rtl/ram_cnt_sched_pkg.sv
// Shared FSM state type and prescaler sizing helpers for the RAM-backed counter sequencer.
package ram_cnt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SW_RD,
    ST_SW_CAP,
    ST_SW_WR,
    ST_H_RD,
    ST_H_CAP,
    ST_H_WR
  } state_e;

  function automatic int presc_term(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz - 1;
  endfunction

  function automatic int presc_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

  localparam int PRESC_TERM = presc_term(50_000_000, 1);
  localparam int PRESC_W    = presc_width(PRESC_TERM);

endpackage

// File: rtl/ram_cnt_sched_if.sv
// Host access port of the counter sequencer: request/grant handshake plus read-data return.
interface ram_cnt_sched_if #(
  parameter int AW = 2,
  parameter int DW = 8
) ();
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata
  );
endinterface

// File: rtl/ram_cnt_sched_tick_gen.sv
// Free-running prescaler: tick_o is high for the single cycle in which the count sits at TERM.
module tick_gen
  import ram_cnt_pkg::*;
#(
  parameter int TERM = PRESC_TERM,
  parameter int W    = PRESC_W
) (
  input  logic clk50M,
  input  logic Reset_N,
  output logic tick_o
);

  logic [W-1:0] count_q, count_d;

  assign tick_o  = (count_q == W'(TERM));
  assign count_d = tick_o ? '0 : count_q + 1'b1;

  always_ff @(posedge clk50M or negedge Reset_N) begin
    if (!Reset_N) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/ram_cnt_sched.sv
// Tick-driven carry-chained RMW sweep over an external sync RAM, arbitrated with a host port.
// Optional carry_o output of the top digit is enabled by defining CNT_CARRY_OUT_EN.
module ram_cnt_sched
  import ram_cnt_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int DW      = 8,
  parameter int MAXVAL  = 59
) (
  input  logic          clk50M,
  input  logic          Reset_N,
  input  logic          cnt_en_i,
  ram_cnt_sched_if.slave host,
  output logic [AW-1:0] ram_addr_o,
  output logic          ram_we_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic          tick_o,
  output logic          busy_o
`ifdef CNT_CARRY_OUT_EN
  ,
  output logic          carry_o
`endif
);

  localparam int            TERM = presc_term(CLK_HZ, TICK_HZ);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [DW-1:0] v_q, v_d;
  logic          pending_q, pending_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic          host_gnt;
  logic          tick_hit, sweep_go, digit_wraps;

  tick_gen #(
    .TERM (TERM),
    .W    (presc_width(TERM))
  ) u_tick_gen (
    .clk50M  (clk50M),
    .Reset_N (Reset_N),
    .tick_o  (tick_o)
  );

  // A tick in IDLE launches the sweep directly, so it beats a host request in the same cycle.
  assign tick_hit    = tick_o & cnt_en_i;
  assign sweep_go    = (state_q == ST_IDLE) && (pending_q || tick_hit);
  assign pending_d   = sweep_go ? 1'b0 : (pending_q | tick_hit);
  assign digit_wraps = (ram_rdata_i >= DW'(MAXVAL));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d       = state_q;
    i_d           = i_q;
    v_d           = v_q;
    ram_addr_d    = ram_addr_q;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata_q;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    host_gnt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sweep_go) begin
          i_d        = '0;
          ram_addr_d = '0;
          state_d    = ST_SW_RD;
        end else if (host.host_req) begin
          host_gnt   = 1'b1;
          ram_addr_d = host.host_addr;
          if (host.host_we) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = host.host_wdata;
            state_d     = ST_H_WR;
          end else begin
            state_d = ST_H_RD;
          end
        end
      end
      ST_SW_RD:  state_d = ST_SW_CAP;
      ST_SW_CAP: begin
        // Write strobe and data are set up here so they are registered during SW_WR.
        v_d         = ram_rdata_i;
        ram_we_d    = 1'b1;
        ram_wdata_d = digit_wraps ? '0 : ram_rdata_i + 1'b1;
        state_d     = ST_SW_WR;
      end
      ST_SW_WR: begin
        if ((v_q >= DW'(MAXVAL)) && (i_q != LAST)) begin
          i_d        = i_q + 1'b1;
          ram_addr_d = i_q + 1'b1;
          state_d    = ST_SW_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_H_RD:  state_d = ST_H_CAP;
      ST_H_CAP: begin
        host_rdata_d  = ram_rdata_i;
        host_rvalid_d = 1'b1;
        state_d       = ST_IDLE;
      end
      ST_H_WR:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk50M or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q       <= ST_IDLE;
      i_q           <= '0;
      v_q           <= '0;
      pending_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      v_q           <= v_d;
      pending_q     <= pending_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign ram_addr_o       = ram_addr_q;
  assign ram_we_o         = ram_we_q;
  assign ram_wdata_o      = ram_wdata_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign host.host_gnt    = host_gnt;
  assign host.host_rvalid = host_rvalid_q;
  assign host.host_rdata  = host_rdata_q;

`ifdef CNT_CARRY_OUT_EN
  logic carry_q, carry_d;

  // Registered alongside the write strobe so the pulse lands in SW_WR of the top digit.
  assign carry_d = (state_q == ST_SW_CAP) && digit_wraps && (i_q == LAST);

  always_ff @(posedge clk50M or negedge Reset_N) begin
    if (!Reset_N) carry_q <= 1'b0;
    else          carry_q <= carry_d;
  end

  assign carry_o = carry_q;
`endif

endmodule

// File: tb/tb_ram_cnt_sched.sv
// Self-checking bench for ram_cnt_sched: sync RAM model, host-read scoreboard, sweep vector table.
module tb_ram_cnt_sched;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;

  logic          clk50M  = 1'b0;
  logic          Reset_N = 1'b0;
  logic          cnt_en  = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          tick;
  logic          busy;
`ifdef CNT_CARRY_OUT_EN
  logic          carry;
  int            carry_cnt = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ram_cnt_sched_if #(.AW(AW), .DW(DW)) host ();

  ram_cnt_sched #(
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .DW      (DW),
    .MAXVAL  (59)
  ) dut (
    .clk50M      (clk50M),
    .Reset_N     (Reset_N),
    .cnt_en_i    (cnt_en),
    .host        (host),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .tick_o      (tick),
`ifdef CNT_CARRY_OUT_EN
    .carry_o     (carry),
`endif
    .busy_o      (busy)
  );

  always #10 clk50M = ~clk50M;

  // Single-port synchronous RAM: read data appears one cycle after the address.
  logic [DW-1:0] mem [DEPTH] = '{default: '0};
  int            wr_cnt = 0;
  int            cyc    = 0;

  always @(posedge clk50M) begin
    cyc <= cyc + 1;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard of host reads: pushed at grant, popped when host_rvalid arrives.
  typedef struct {
    logic [DW-1:0] data;
    int            gnt_cyc;
  } rd_exp_t;

  rd_exp_t sb [$];
  rd_exp_t mon_e;

  always @(negedge clk50M) begin
    if (Reset_N && host.host_rvalid) begin
      if (sb.size() == 0) begin
        check(1'b0, "rvalid_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check(host.host_rdata == mon_e.data, "host_rdata", host.host_rdata, mon_e.data);
        check(cyc - mon_e.gnt_cyc == 3, "rd_latency", cyc - mon_e.gnt_cyc, 3);
      end
    end
  end

`ifdef CNT_CARRY_OUT_EN
  always @(negedge clk50M) begin
    if (Reset_N && carry) begin
      carry_cnt++;
      check(ram_we && (ram_addr == AW'(DEPTH - 1)) && (ram_wdata == '0), "carry_align",
            {ram_we, ram_addr}, {1'b1, 2'd3});
    end
  end
`endif

  function automatic logic [31:0] outs_now();
    logic c;
    c = 1'b0;
`ifdef CNT_CARRY_OUT_EN
    c = carry;
`endif
    return {8'd0, c, ram_we, ram_addr, ram_wdata, host.host_gnt, host.host_rvalid,
            host.host_rdata, tick, busy};
  endfunction

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk50M);
      n++;
    end while (!(tick && !busy) && n < 60);
    if (!(tick && !busy)) check(1'b0, "tick_timeout", n, 60);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    host.host_req   = 1'b1;
    host.host_we    = 1'b1;
    host.host_addr  = a;
    host.host_wdata = d;
    #1;
    while (!host.host_gnt && n < 200) begin
      @(negedge clk50M);
      n++;
      #1;
    end
    if (!host.host_gnt) check(1'b0, "wr_gnt_timeout", n, 200);
    @(negedge clk50M);
    host.host_req = 1'b0;
    host.host_we  = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, output int nwait);
    nwait = 0;
    host.host_req  = 1'b1;
    host.host_we   = 1'b0;
    host.host_addr = a;
    #1;
    while (!host.host_gnt && nwait < 200) begin
      @(negedge clk50M);
      nwait++;
      #1;
    end
    if (host.host_gnt) begin
      check(!busy, "gnt_while_busy", busy, 0);
      sb.push_back('{data: exp, gnt_cyc: cyc});
    end else begin
      check(1'b0, "rd_gnt_timeout", nwait, 200);
    end
    @(negedge clk50M);
    host.host_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk50M);
      n++;
    end
    if (sb.size() != 0) check(1'b0, "rvalid_timeout", sb.size(), 0);
  endtask

  task automatic run_sweep(output int nb);
    int n;
    wait_tick(n);
    cnt_en = 1'b1;
    @(negedge clk50M);
    cnt_en = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk50M);
    end
  endtask

  typedef struct {
    int init [DEPTH];
    int exp  [DEPTH];
    int busy;
    int carry;
  } vec_t;

  function automatic vec_t mk(input int i0, i1, i2, i3, e0, e1, e2, e3, nb, nc);
    vec_t v;
    v.init[0] = i0; v.init[1] = i1; v.init[2] = i2; v.init[3] = i3;
    v.exp[0]  = e0; v.exp[1]  = e1; v.exp[2]  = e2; v.exp[3]  = e3;
    v.busy    = nb;
    v.carry   = nc;
    return v;
  endfunction

  initial begin
    vec_t vecs [8];
    int   n, nb, t_prev, wc0, cb;

    vecs[0] = mk( 0,  0,  0,   0,   1,  0,  0,  0,  3, 0);
    vecs[1] = mk(59, 59,  0,   0,   0,  0,  1,  0,  9, 0);
    vecs[2] = mk(58, 59, 59,   7,  59, 59, 59,  7,  3, 0);
    vecs[3] = mk(59, 59, 59,  59,   0,  0,  0,  0, 12, 1);
    vecs[4] = mk(70,  3,  0,   0,   0,  4,  0,  0,  6, 0);
    vecs[5] = mk(59, 12, 59,  59,   0, 13, 59, 59,  6, 0);
    vecs[6] = mk(59, 59, 59,  58,   0,  0,  0, 59, 12, 0);
    vecs[7] = mk(59, 59, 59, 200,   0,  0,  0,  0, 12, 1);

    host.host_req   = 1'b0;
    host.host_we    = 1'b0;
    host.host_addr  = '0;
    host.host_wdata = '0;
    t_prev = 0;
    cb     = 0;

    repeat (3) @(negedge clk50M);
    #1;
    check(outs_now() == '0, "reset_outputs", outs_now(), 0);

    // Free-running count from an all-zero RAM: entry 0 steps 1, 2, 3.
    cnt_en = 1'b1;
    @(negedge clk50M);
    Reset_N = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      if (k == 1) check(n == 9, "first_tick", n, 9);
      else        check(cyc - t_prev == 10, "tick_period", cyc - t_prev, 10);
      t_prev = cyc;
      @(negedge clk50M);
      nb = 0;
      while (busy && nb < 100) begin
        nb++;
        @(negedge clk50M);
      end
      check(nb == 3, "t1_busy", nb, 3);
      check(mem[0] == DW'(k), "t1_entry0", mem[0], k);
    end
    cnt_en = 1'b0;

    // Table of seeded sweeps, read back through the host port.
    for (int v = 0; v < 8; v++) begin
      for (int a = 0; a < DEPTH; a++) host_write(AW'(a), DW'(vecs[v].init[a]));
`ifdef CNT_CARRY_OUT_EN
      cb = carry_cnt;
`endif
      run_sweep(nb);
      check(nb == vecs[v].busy, $sformatf("vec%0d_busy", v), nb, vecs[v].busy);
      for (int a = 0; a < DEPTH; a++) host_read(AW'(a), DW'(vecs[v].exp[a]), n);
      drain();
`ifdef CNT_CARRY_OUT_EN
      check(carry_cnt - cb == vecs[v].carry, $sformatf("vec%0d_carry", v),
            carry_cnt - cb, vecs[v].carry);
`endif
    end

    // Tick and host read in the same IDLE cycle: sweep first, host right after it.
    host_write(2'd0, 8'd59);
    host_write(2'd1, 8'd59);
    host_write(2'd2, 8'd0);
    host_write(2'd3, 8'd0);
    wait_tick(n);
    cnt_en = 1'b1;
    fork
      begin
        @(negedge clk50M);
        cnt_en = 1'b0;
      end
    join_none
    host_read(2'd1, 8'd0, n);
    check(n == 10, "t4_gnt_after_sweep", n, 10);
    host_read(2'd2, 8'd1, n);
    drain();

    // Host read raised mid-sweep is held off until the sweep ends.
    host_write(2'd0, 8'd59);
    host_write(2'd1, 8'd59);
    host_write(2'd2, 8'd59);
    host_write(2'd3, 8'd3);
    wait_tick(n);
    cnt_en = 1'b1;
    @(negedge clk50M);
    cnt_en = 1'b0;
    @(negedge clk50M);
    check(busy, "t3_busy_at_req", busy, 1);
    host_read(2'd3, 8'd4, n);
    check(n == 11, "t3_gnt_wait", n, 11);
    host_read(2'd0, 8'd0, n);
    drain();

    // Reset asserted in SW_CAP abandons the sweep without writing.
    host_write(2'd0, 8'd10);
    wait_tick(n);
    wc0 = wr_cnt;
    cnt_en = 1'b1;
    @(negedge clk50M);
    cnt_en = 1'b0;
    @(negedge clk50M);
    check(busy && !ram_we, "t5_in_cap", {busy, ram_we}, 2);
    Reset_N = 1'b0;
    #1;
    check(outs_now() == '0, "t5_reset_outputs", outs_now(), 0);
    repeat (3) @(negedge clk50M);
    check(wr_cnt == wc0, "t5_no_write", wr_cnt, wc0);
    check(mem[0] == 8'd10, "t5_entry0_kept", mem[0], 10);
    Reset_N = 1'b1;
    run_sweep(nb);
    check(nb == 3, "t5_busy_after", nb, 3);
    host_read(2'd0, 8'd11, n);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
